// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolver: computes actual control-flow outcome, redirects fetch on a
// misprediction, trains the predictor one cycle later and keeps resolve/mispredict statistics.
module branch_resolve_unit #(
    parameter int unsigned RECOVER_CYCLES = 1,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_valid,
    input  logic             ex_stall,
    input  logic             ex_is_branch,
    input  logic             ex_is_jal,
    input  logic             ex_is_jalr,
    input  logic             ex_cond,
    input  logic [31:0]      ex_pc,
    input  logic [31:0]      ex_imm,
    input  logic [31:0]      ex_rs1,
    input  logic [31:0]      ex_pred_pc,
    input  logic [4:0]       ex_bhsr,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             upd_valid,
    output logic             upd_taken,
    output logic [31:0]      upd_pc,
    output logic [31:0]      upd_target,
    output logic [4:0]       upd_bhsr,
    output logic [CNT_W-1:0] cnt_ctrl,
    output logic [CNT_W-1:0] cnt_mispred
);

    typedef enum logic [0:0] {StIdle, StRecover} state_e;

    localparam logic [2:0] RcInit = 3'(RECOVER_CYCLES - 1);

    state_e            state_q, state_d;
    logic [2:0]        rc_q, rc_d;
    logic              upd_valid_q, upd_valid_d;
    logic              upd_taken_q, upd_taken_d;
    logic [31:0]       upd_pc_q, upd_pc_d;
    logic [31:0]       upd_target_q, upd_target_d;
    logic [4:0]        upd_bhsr_q, upd_bhsr_d;
    logic [CNT_W-1:0]  cnt_ctrl_q, cnt_ctrl_d;
    logic [CNT_W-1:0]  cnt_mispred_q, cnt_mispred_d;

    logic        is_ctrl;
    logic        resolve;
    logic        taken;
    logic        mispred;
    logic [31:0] target;
    logic [31:0] fallthrough;
    logic [31:0] actual_next;

    // Resolve gated by reset so every combinational output is quiet while in reset.
    always_comb begin
        is_ctrl     = ex_is_branch | ex_is_jal | ex_is_jalr;
        resolve     = reset & ex_valid & ~ex_stall & (state_q == StIdle) & is_ctrl;
        fallthrough = ex_pc + 32'd4;
        if (ex_is_jalr) begin
            target = (ex_rs1 + ex_imm) & ~32'h1;
        end else begin
            target = ex_pc + ex_imm;
        end
        taken       = ex_is_jalr | ex_is_jal | (ex_is_branch & ex_cond);
        actual_next = taken ? target : fallthrough;
        mispred     = resolve & (actual_next != ex_pred_pc);
    end

    always_comb begin
        state_d       = state_q;
        rc_d          = rc_q;
        upd_valid_d   = resolve;
        upd_taken_d   = upd_taken_q;
        upd_pc_d      = upd_pc_q;
        upd_target_d  = upd_target_q;
        upd_bhsr_d    = upd_bhsr_q;
        cnt_ctrl_d    = cnt_ctrl_q;
        cnt_mispred_d = cnt_mispred_q;

        unique case (state_q)
            StIdle: begin
                if (mispred) begin
                    state_d = StRecover;
                    rc_d    = RcInit;
                end
            end
            StRecover: begin
                if (rc_q == 3'd0) begin
                    state_d = StIdle;
                end else begin
                    rc_d = rc_q - 3'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (resolve) begin
            upd_taken_d  = taken;
            upd_pc_d     = ex_pc;
            upd_target_d = target;
            upd_bhsr_d   = ex_bhsr;
            if (cnt_ctrl_q != '1) begin
                cnt_ctrl_d = cnt_ctrl_q + 1'b1;
            end
        end
        if (mispred && (cnt_mispred_q != '1)) begin
            cnt_mispred_d = cnt_mispred_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            rc_q          <= 3'd0;
            upd_valid_q   <= 1'b0;
            upd_taken_q   <= 1'b0;
            upd_pc_q      <= 32'd0;
            upd_target_q  <= 32'd0;
            upd_bhsr_q    <= 5'd0;
            cnt_ctrl_q    <= '0;
            cnt_mispred_q <= '0;
        end else begin
            state_q       <= state_d;
            rc_q          <= rc_d;
            upd_valid_q   <= upd_valid_d;
            upd_taken_q   <= upd_taken_d;
            upd_pc_q      <= upd_pc_d;
            upd_target_q  <= upd_target_d;
            upd_bhsr_q    <= upd_bhsr_d;
            cnt_ctrl_q    <= cnt_ctrl_d;
            cnt_mispred_q <= cnt_mispred_d;
        end
    end

    assign redirect_valid = mispred;
    assign redirect_pc    = mispred ? actual_next : 32'd0;
    assign flush_if_id    = mispred;
    assign flush_id_ex    = mispred;
    assign upd_valid      = upd_valid_q;
    assign upd_taken      = upd_taken_q;
    assign upd_pc         = upd_pc_q;
    assign upd_target     = upd_target_q;
    assign upd_bhsr       = upd_bhsr_q;
    assign cnt_ctrl       = cnt_ctrl_q;
    assign cnt_mispred    = cnt_mispred_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed literal checks plus randomized traffic
// compared every cycle against a behavioural model; a 3-bit-counter instance exercises saturation.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ex_valid = 1'b0, ex_stall = 1'b0;
    logic        ex_is_branch = 1'b0, ex_is_jal = 1'b0, ex_is_jalr = 1'b0, ex_cond = 1'b0;
    logic [31:0] ex_pc = '0, ex_imm = '0, ex_rs1 = '0, ex_pred_pc = '0;
    logic [4:0]  ex_bhsr = '0;

    logic        redirect_valid, flush_if_id, flush_id_ex, upd_valid, upd_taken;
    logic [31:0] redirect_pc, upd_pc, upd_target, cnt_ctrl, cnt_mispred;
    logic [4:0]  upd_bhsr;

    logic        s_redirect_valid, s_flush_if_id, s_flush_id_ex, s_upd_valid, s_upd_taken;
    logic [31:0] s_redirect_pc, s_upd_pc, s_upd_target;
    logic [4:0]  s_upd_bhsr;
    logic [2:0]  s_cnt_ctrl, s_cnt_mispred;

    int tests = 0;
    int fails = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    branch_resolve_unit u_dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_stall(ex_stall),
        .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
        .ex_cond(ex_cond), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
        .ex_pred_pc(ex_pred_pc), .ex_bhsr(ex_bhsr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .upd_valid(upd_valid), .upd_taken(upd_taken), .upd_pc(upd_pc),
        .upd_target(upd_target), .upd_bhsr(upd_bhsr),
        .cnt_ctrl(cnt_ctrl), .cnt_mispred(cnt_mispred)
    );

    branch_resolve_unit #(.RECOVER_CYCLES(1), .CNT_W(3)) u_sat (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_stall(ex_stall),
        .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
        .ex_cond(ex_cond), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
        .ex_pred_pc(ex_pred_pc), .ex_bhsr(ex_bhsr),
        .redirect_valid(s_redirect_valid), .redirect_pc(s_redirect_pc),
        .flush_if_id(s_flush_if_id), .flush_id_ex(s_flush_id_ex),
        .upd_valid(s_upd_valid), .upd_taken(s_upd_taken), .upd_pc(s_upd_pc),
        .upd_target(s_upd_target), .upd_bhsr(s_upd_bhsr),
        .cnt_ctrl(s_cnt_ctrl), .cnt_mispred(s_cnt_mispred)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          rec_left;
    logic        m_upd_valid, m_upd_taken;
    logic [31:0] m_upd_pc, m_upd_target;
    logic [4:0]  m_upd_bhsr;
    longint      m_ctrl, m_mis, m_sctrl, m_smis;

    function automatic void eval(output logic res, output logic mis, output logic [31:0] nxt,
                                 output logic tk, output logic [31:0] tgt);
        tgt = ex_pc + ex_imm;
        tk  = 1'b0;
        if (ex_is_jalr) begin
            tgt    = ex_rs1 + ex_imm;
            tgt[0] = 1'b0;
            tk     = 1'b1;
        end else if (ex_is_jal) begin
            tk = 1'b1;
        end else if (ex_is_branch) begin
            tk = ex_cond;
        end
        res = (reset === 1'b1) && ex_valid && !ex_stall && (rec_left == 0) &&
              (ex_is_branch || ex_is_jal || ex_is_jalr);
        nxt = tk ? tgt : ex_pc + 32'd4;
        mis = res && (nxt != ex_pred_pc);
    endfunction

    always @(posedge clk or negedge reset) begin
        logic res, mis, tk;
        logic [31:0] nxt, tgt;
        if (!reset) begin
            rec_left = 0;
            m_upd_valid = 0; m_upd_taken = 0; m_upd_pc = 0; m_upd_target = 0; m_upd_bhsr = 0;
            m_ctrl = 0; m_mis = 0; m_sctrl = 0; m_smis = 0;
        end else begin
            eval(res, mis, nxt, tk, tgt);
            if (rec_left > 0) rec_left--;
            else if (mis) rec_left = 1;
            m_upd_valid = res;
            if (res) begin
                m_upd_taken = tk; m_upd_pc = ex_pc; m_upd_target = tgt; m_upd_bhsr = ex_bhsr;
                m_ctrl++;
                if (m_sctrl < 7) m_sctrl++;
            end
            if (mis) begin
                m_mis++;
                if (m_smis < 7) m_smis++;
            end
        end
    end

    always @(negedge clk) begin
        logic res, mis, tk;
        logic [31:0] nxt, tgt;
        if (started) begin
            eval(res, mis, nxt, tk, tgt);
            chk("redirect_valid", redirect_valid, mis);
            chk("redirect_pc", redirect_pc, mis ? nxt : 32'd0);
            chk("flush_if_id", flush_if_id, mis);
            chk("flush_id_ex", flush_id_ex, mis);
            chk("upd_valid", upd_valid, m_upd_valid);
            chk("upd_taken", upd_taken, m_upd_taken);
            chk("upd_pc", upd_pc, m_upd_pc);
            chk("upd_target", upd_target, m_upd_target);
            chk("upd_bhsr", upd_bhsr, m_upd_bhsr);
            chk("cnt_ctrl", cnt_ctrl, m_ctrl);
            chk("cnt_mispred", cnt_mispred, m_mis);
            chk("sat_cnt_ctrl", s_cnt_ctrl, m_sctrl);
            chk("sat_cnt_mispred", s_cnt_mispred, m_smis);
            chk("sat_redirect_valid", s_redirect_valid, mis);
            chk("sat_upd_valid", s_upd_valid, m_upd_valid);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic v, input logic b, input logic j, input logic jr,
                         input logic c, input logic [31:0] pc, input logic [31:0] imm,
                         input logic [31:0] rs1, input logic [31:0] pred);
        ex_valid = v; ex_is_branch = b; ex_is_jal = j; ex_is_jalr = jr; ex_cond = c;
        ex_pc = pc; ex_imm = imm; ex_rs1 = rs1; ex_pred_pc = pred;
        ex_bhsr = 5'($urandom);
    endtask

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        started = 1'b1;
        #1;
        chk("rst_upd_valid", upd_valid, 0);
        chk("rst_cnt_ctrl", cnt_ctrl, 0);
        edge_wait();

        // mispredicted taken BEQ
        drive(1, 1, 0, 0, 1, 32'h100, 32'h20, 0, 32'h104);
        #1;
        chk("beq_redirect", redirect_valid, 1);
        chk("beq_redirect_pc", redirect_pc, 32'h120);
        chk("beq_flush", {flush_if_id, flush_id_ex}, 2'b11);
        edge_wait();
        chk("beq_upd", {upd_valid, upd_taken}, 2'b11);
        chk("beq_upd_target", upd_target, 32'h120);
        chk("beq_cnt_mispred", cnt_mispred, 1);

        // JAL in the squashed cycle is ignored
        drive(1, 0, 1, 0, 0, 32'h300, 32'h8, 0, 32'h0);
        #1;
        chk("squash_redirect", redirect_valid, 0);
        edge_wait();
        chk("squash_upd_valid", upd_valid, 0);
        chk("squash_cnt_ctrl", cnt_ctrl, 1);

        // correctly predicted not-taken BNE
        drive(1, 1, 0, 0, 0, 32'h200, 32'h40, 0, 32'h204);
        #1;
        chk("bne_redirect", redirect_valid, 0);
        edge_wait();
        chk("bne_upd", {upd_valid, upd_taken}, 2'b10);
        chk("bne_cnts", {cnt_ctrl, cnt_mispred}, {32'd2, 32'd1});

        // JALR correct then mispredicted
        drive(1, 0, 0, 1, 0, 32'h500, 32'h4, 32'h1003, 32'h1006);
        #1;
        chk("jalr_ok_redirect", redirect_valid, 0);
        edge_wait();
        chk("jalr_ok_target", upd_target, 32'h1006);
        drive(1, 0, 0, 1, 0, 32'h500, 32'h4, 32'h1003, 32'h3C);
        #1;
        chk("jalr_bad_redirect", {redirect_valid, redirect_pc}, {1'b1, 32'h1006});
        edge_wait();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        edge_wait();

        // stalled branch resolves once on release
        ex_stall = 1'b1;
        drive(1, 1, 0, 0, 0, 32'h400, 32'h10, 0, 32'h404);
        for (int i = 0; i < 3; i++) begin
            edge_wait();
            chk("stall_no_upd", upd_valid, 0);
        end
        ex_stall = 1'b0;
        edge_wait();
        chk("stall_release_upd", upd_valid, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        edge_wait();
        chk("stall_single_pulse", upd_valid, 0);
        chk("stall_cnt_ctrl", cnt_ctrl, 5);

        // reset in the middle of recovery
        drive(1, 0, 1, 0, 0, 32'h600, 32'h100, 0, 32'h604);
        edge_wait();
        #1 reset = 1'b0;
        #1;
        chk("midrst_cnt", {cnt_ctrl, cnt_mispred}, 64'd0);
        chk("midrst_upd_valid", upd_valid, 0);
        chk("midrst_redirect", redirect_valid, 0);
        #1 reset = 1'b1;
        #1;
        chk("postrst_redirect", {redirect_valid, redirect_pc}, {1'b1, 32'h700});
        edge_wait();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] pc, imm, rs1, pred, jt;
            pc  = $urandom;
            imm = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 255)) - 32'd128;
            rs1 = $urandom;
            jt  = (rs1 + imm) & ~32'h1;
            case ($urandom_range(0, 3))
                0: pred = pc + 32'd4;
                1: pred = pc + imm;
                2: pred = jt;
                default: pred = $urandom;
            endcase
            ex_stall = ($urandom_range(0, 3) == 0);
            drive($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), pc, imm, rs1, pred);
            if ($urandom_range(0, 149) == 0) begin
                #1 reset = 1'b0;
                @(negedge clk);
                #1 reset = 1'b1;
            end
            edge_wait();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        edge_wait();
        chk("sat_final_cnt_ctrl", s_cnt_ctrl, 3'd7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- EX-stage resolver; the update-side counterpart of the fetch-stage gshare/BTB predictor.
- Computes each control-flow instruction's actual outcome and compares it with the PC the predictor chose.
- On a wrong prediction it redirects fetch and flushes the younger stages.
- Drives a registered training interface back to the predictor (valid, taken, target, history) and keeps misprediction statistics.

Parameters:
- RECOVER_CYCLES, 1: cycles after a redirect during which EX contents are treated as squashed bubbles (1..7).
- CNT_W, 32: width of the statistics counters.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- ex_valid  input  1  EX holds a real (non-bubble) instruction.
- ex_stall  input  1  pipeline stalled; EX instruction is held, so it is not resolved this cycle.
- ex_is_branch  input  1  conditional branch (BEQ/BNE/BLT/BGE/BLTU/BGEU).
- ex_is_jal  input  1  JAL.
- ex_is_jalr  input  1  JALR.
- ex_cond  input  1  ALU branch-condition result.
- ex_pc  input  32  PC of the EX instruction.
- ex_imm  input  32  sign-extended immediate.
- ex_rs1  input  32  forwarded rs1 value.
- ex_pred_pc  input  32  next-PC the predictor chose for this instruction.
- ex_bhsr  input  5  global history captured at fetch of this instruction.
- redirect_valid  output  1  fetch must load redirect_pc next edge.
- redirect_pc  output  32  corrected next PC.
- flush_if_id  output  1  squash the IF/ID register.
- flush_id_ex  output  1  squash the ID/EX register.
- upd_valid  output  1  predictor training strobe; connects to taken_or_not.
- upd_taken  output  1  actual direction; connects to is_taken.
- upd_pc  output  32  PC being trained; connects to ID_EX_PC.
- upd_target  output  32  actual taken target; connects to target_addr.
- upd_bhsr  output  5  history used for the PHT index; connects to ID_EX_BHSR.
- cnt_ctrl  output  CNT_W  resolved control-flow instructions.
- cnt_mispred  output  CNT_W  mispredictions.

Behaviour:
- Resolve condition: resolve = ex_valid & ~ex_stall & (state==IDLE) & (ex_is_branch|ex_is_jal|ex_is_jalr). At most one of the three type flags is set; if more than one is set, the priority is jalr > jal > branch.
- Targets (all arithmetic 32-bit, carry discarded, so wrap-around is allowed):
  - JAL and branch target = ex_pc + ex_imm.
  - JALR target = (ex_rs1 + ex_imm) & ~32'h1.
  - fallthrough = ex_pc + 4.
- Outcome:
  - taken = jal | jalr | (branch & ex_cond).
  - actual_next = taken ? target : fallthrough.
  - mispred = resolve & (actual_next != ex_pred_pc).
- Combinational, same cycle: redirect_valid = flush_if_id = flush_id_ex = mispred; redirect_pc = actual_next (0 when redirect_valid is 0).
- Registered, latency 1: on an edge where resolve=1, the upd_* outputs capture
  - upd_valid = 1, upd_taken = taken, upd_pc = ex_pc, upd_target = target, upd_bhsr = ex_bhsr.
  - Otherwise upd_valid = 0 and the other upd_* outputs hold their values.
  - upd_valid is a one-cycle pulse per resolved instruction.
- FSM states are IDLE and RECOVER, with a 3-bit down-counter rc.
  - IDLE, mispred=1 → RECOVER, rc = RECOVER_CYCLES-1.
  - RECOVER, rc==0 → IDLE; otherwise rc decrements.
  - In RECOVER, ex_valid is ignored: no resolve, no redirect, no update, no count.
- ex_stall:
  - The stalled instruction resolves only in the cycle its stall drops, so it is counted and trained exactly once.
  - The FSM still advances during stall.
- Counters:
  - cnt_ctrl increments on resolve.
  - cnt_mispred increments on mispred.
  - Both saturate at all-ones.
- Reset (asynchronous, any cycle, including mid-RECOVER):
  - state = IDLE, rc = 0.
  - upd_valid = 0, upd_taken = 0, upd_pc = 0, upd_target = 0, upd_bhsr = 0.
  - Both counters = 0.
  - Combinational outputs are 0 while reset is low, because resolve is gated by reset.
- Correct prediction, including a correct not-taken branch: no flush; update and count only.

Test Plan:
- BEQ at pc=0x100, imm=0x20, cond=1, pred_pc=0x104 → same cycle: redirect_valid=1, redirect_pc=0x120, both flushes=1. Next edge: upd_valid=1, upd_taken=1, upd_target=0x120. cnt_mispred=1.
- BNE at pc=0x200, cond=0, pred_pc=0x204 → no redirect/flush. Next cycle: upd_valid=1, upd_taken=0. cnt_ctrl+1, cnt_mispred unchanged.
- JALR with rs1=0x1003, imm=0x4, pred_pc=0x1006 → target=0x1006, no mispredict. Repeat with pred_pc=0x3C → redirect_pc=0x1006.
- Mispredict followed by ex_valid=1 JAL in the next cycle (RECOVER_CYCLES=1) → second instruction ignored: no upd_valid, counters unchanged. A third instruction one cycle later resolves normally.
- Branch held with ex_stall=1 for 3 cycles, then released → exactly one upd_valid pulse and cnt_ctrl+1.
- Assert reset low mid-RECOVER with counters nonzero → counters=0 and upd_valid=0 immediately. After release, a mispredict redirects with no lingering RECOVER. Counter preset near all-ones → saturates, no wrap.
